msrv32_store_buffer: RTL

Parametrised successor to the combinational store unit. It formats RV32I stores (SB/SH/SW) into word-aligned address, lane-replicated data and byte mask. Formatted stores are queued in a DEPTH-entry FIFO, so the pipeline does not stall on AHB wait states. A small FSM drains the FIFO to the AHB-Lite data port in strict program order, one non-pipelined transfer at a time. Adds misalignment/illegal-size detection and a busy flag for fence/drain.

---
 rtl/msrv32_store_buffer_if.sv | 26 ++
 rtl/msrv32_store_buffer.sv | 76 +++++++
 2 files changed

// File: rtl/msrv32_store_buffer_if.sv
// msrv32_store_buffer_if: pipeline store request and AHB-Lite write port bundle
interface msrv32_store_buffer_if #(parameter int ADDR_W = 32);
  logic [1:0]        funct3_in;
  logic [ADDR_W-1:0] iadder_in;
  logic [31:0]       rs2_in;
  logic              mem_wr_req_in;
  logic              store_ready_out;
  logic              misaligned_out;
  logic              busy_out;
  logic              ahb_ready_in;
  logic [ADDR_W-1:0] d_addr_out;
  logic [31:0]       data_out;
  logic [3:0]        wr_mask_out;
  logic [1:0]        ahb_htrans_out;
  logic              wr_req_out;
  modport slave (
    input  funct3_in, iadder_in, rs2_in, mem_wr_req_in, ahb_ready_in,
    output store_ready_out, misaligned_out, busy_out,
           d_addr_out, data_out, wr_mask_out, ahb_htrans_out, wr_req_out
  );
  modport master (
    output funct3_in, iadder_in, rs2_in, mem_wr_req_in, ahb_ready_in,
    input  store_ready_out, misaligned_out, busy_out,
           d_addr_out, data_out, wr_mask_out, ahb_htrans_out, wr_req_out
  );
endinterface

// File: rtl/msrv32_store_buffer.sv
// msrv32_store_buffer: formats RV32I stores, queues them and drains them in order to AHB-Lite
module msrv32_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input logic clk_in,
  input logic rst_in,
  msrv32_store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state, next;
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [PW:0]       count;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [31:0]       data_q [DEPTH];
  logic [3:0]        mask_q [DEPTH];
  logic [31:0]       fmt_data;
  logic [3:0]        fmt_mask;
  logic [ADDR_W-1:0] d_addr_r;
  logic [31:0]       data_r;
  logic [3:0]        mask_r;
  logic              ready, mis, push, pop, load_addr, load_data;
  assign fmt_data = bus.funct3_in == 2'b00 ? {4{bus.rs2_in[7:0]}}
                  : bus.funct3_in == 2'b01 ? {2{bus.rs2_in[15:0]}} : bus.rs2_in;
  assign fmt_mask = bus.funct3_in == 2'b00 ? 4'b0001 << bus.iadder_in[1:0]
                  : bus.funct3_in == 2'b01 ? 4'b0011 << {bus.iadder_in[1], 1'b0} : 4'b1111;
  assign mis = bus.mem_wr_req_in & ((bus.funct3_in == 2'b01 & bus.iadder_in[0]) |
                                    (bus.funct3_in == 2'b10 & |bus.iadder_in[1:0]) |
                                    bus.funct3_in == 2'b11);
  // A pop in the same cycle never frees a slot: ready depends on count alone
  assign ready = count != (PW+1)'(DEPTH);
  assign push  = bus.mem_wr_req_in & ready & ~mis;
  assign pop   = state == DATA & bus.ahb_ready_in;
  always_ff @(posedge clk_in)
    if (push) begin
      addr_q[wr_ptr] <= {bus.iadder_in[ADDR_W-1:2], 2'b00};
      data_q[wr_ptr] <= fmt_data;
      mask_q[wr_ptr] <= fmt_mask;
    end
  always_ff @(posedge clk_in)
    if (rst_in) begin
      state    <= IDLE;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      d_addr_r <= '0;
      data_r   <= '0;
      mask_r   <= '0;
    end else begin
      state <= next;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      if (load_addr) d_addr_r <= addr_q[rd_ptr];
      if (load_data) begin
        data_r <= data_q[rd_ptr];
        mask_r <= mask_q[rd_ptr];
      end else if (pop) mask_r <= '0;
    end
  always_comb begin
    next      = state == IDLE ? (count != '0 ? ADDR : IDLE)
              : state == ADDR ? (bus.ahb_ready_in ? DATA : ADDR)
              : (bus.ahb_ready_in ? IDLE : DATA);
    load_addr = state == IDLE & count != '0;
    load_data = state == ADDR & bus.ahb_ready_in;
    bus.ahb_htrans_out = state == ADDR ? 2'b10 : 2'b00;
    bus.wr_req_out     = state == ADDR;
  end
  assign bus.store_ready_out = ready;
  assign bus.misaligned_out  = mis;
  assign bus.busy_out        = count != '0 | state != IDLE;
  assign bus.d_addr_out      = d_addr_r;
  assign bus.data_out        = data_r;
  assign bus.wr_mask_out     = mask_r;
endmodule
